// File: rtl/bon_pkg.sv
// Shared types and default configuration for the bon pattern-match scanner.
package bon_pkg;

    localparam int DATA_W_DEF  = 10;
    localparam int ADDR_W_DEF  = 10;
    localparam int PAT_LEN_DEF = 4;
    localparam logic [3:0] PATTERN_DEF = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bon_if.sv
// Memory read port plus host start/fin/result handshake of the bon scanner.
interface bon_if #(
    parameter int DATA_W = bon_pkg::DATA_W_DEF,
    parameter int ADDR_W = bon_pkg::ADDR_W_DEF
) ();
    logic              start;
    logic [DATA_W-1:0] data;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              flag;
    logic              fin;
    logic [DATA_W-1:0] result;

    modport master (input start, data, output en, addr, flag, fin, result);
    modport slave  (output start, data, input en, addr, flag, fin, result);
endinterface

// File: rtl/bon_matcher.sv
// Combinational window compare of one word against PATTERN.
// BON_CIRCULAR_EN adds windows that wrap from bit 0 around to bit DATA_W-1.
module bon_matcher
    import bon_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(PATTERN_DEF)
) (
    input  logic [DATA_W-1:0] data,
    output logic              match
);

`ifdef BON_CIRCULAR_EN
    localparam int LAST  = DATA_W - 1;
    localparam int SRC_W = DATA_W + PAT_LEN - 1;
    logic [SRC_W-1:0] src_s;

    // Extend the word with its own low bits so wrapped windows become linear slices
    always_comb begin
        src_s = {SRC_W{1'b0}};
        for (int j = 0; j < SRC_W; j++) begin
            src_s[j] = data[j % DATA_W];
        end
    end
`else
    localparam int LAST = DATA_W - PAT_LEN;
    logic [DATA_W-1:0] src_s;
    assign src_s = data;
`endif

    // Any overlapping window equal to PATTERN raises match
    always_comb begin
        match = 1'b0;
        for (int i = 0; i <= LAST; i++) begin
            if (src_s[i +: PAT_LEN] == PATTERN) begin
                match = 1'b1;
            end else begin
                match = match;
            end
        end
    end

endmodule

// File: rtl/bon.sv
// bon: scans every memory address once after start, counts words containing PATTERN.
// Optional macro BON_CIRCULAR_EN enables circular (wrap-around) windows in bon_matcher.
module bon
    import bon_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(PATTERN_DEF)
) (
    input  logic  clk,
    input  logic  rst,
    bon_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] COUNT_MAX = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] COUNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic              en_r;
    logic              fin_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] count_r;
    logic              match_s;
    logic              flag_s;

    bon_matcher #(
        .DATA_W  (DATA_W),
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .data  (bus.data),
        .match (match_s)
    );

    // data is don't-care outside SCAN, so the match is gated by the read strobe
    assign flag_s = en_r & match_s;

    // Scan FSM: walks addresses 0..ADDR_LAST, accumulates a saturating match count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            fin_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            count_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= SCAN;
                        en_r    <= 1'b1;
                        fin_r   <= 1'b0;
                        addr_r  <= {ADDR_W{1'b0}};
                        count_r <= {DATA_W{1'b0}};
                    end
                end
                SCAN: begin
                    if (flag_s && (count_r != COUNT_MAX)) begin
                        count_r <= count_r + COUNT_ONE;
                    end
                    if (addr_r == ADDR_LAST) begin
                        state_r <= DONE;
                        en_r    <= 1'b0;
                        fin_r   <= 1'b1;
                    end else begin
                        addr_r <= addr_r + ADDR_ONE;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                    en_r    <= 1'b0;
                    fin_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en     = en_r;
    assign bus.addr   = addr_r;
    assign bus.flag   = flag_s;
    assign bus.fin    = fin_r;
    assign bus.result = count_r;

endmodule

// File: tb/tb_bon.sv
// Table-driven bench for bon: memory images with hand-computed flag positions and counts.
module tb_bon;

`ifdef BON_CIRCULAR_EN
    localparam logic CIRC = 1'b1;
`else
    localparam logic CIRC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [9:0] mem [0:1023];

    always #5 clk = ~clk;

    bon_if #(.DATA_W(10), .ADDR_W(10)) bus ();

    // Idle data is a matching word so an ungated flag would show up
    assign bus.data = bus.en ? mem[bus.addr] : 10'h00B;

    bon dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] fill;
        logic       ff;
        logic [9:0] a1;
        logic [9:0] w1;
        logic       f1;
        logic [9:0] a2;
        logic [9:0] w2;
        logic       f2;
        logic [9:0] res;
    } vec_t;

    vec_t vecs [6];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input int v);
        for (int a = 0; a < 1024; a++) mem[a] = vecs[v].fill;
        mem[vecs[v].a1] = vecs[v].w1;
        mem[vecs[v].a2] = vecs[v].w2;
    endtask

    function automatic logic exp_flag(input int v, input int a);
        if (a == int'(vecs[v].a1)) return vecs[v].f1;
        else if (a == int'(vecs[v].a2)) return vecs[v].f2;
        else return vecs[v].ff;
    endfunction

    task automatic apply_reset(input string tag);
        bus.start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check({tag, "_reset_state"}, {bus.en, bus.fin, bus.flag, bus.addr, bus.result}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_state"}, {bus.en, bus.fin, bus.flag, bus.addr}, 32'd0);
    endtask

    task automatic scan(input int v, input string tag);
        int addr_err = 0;
        int flag_err = 0;
        int fin_err  = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 1024; c++) begin
            if (bus.en !== 1'b1 || bus.addr !== c[9:0]) addr_err++;
            if (bus.flag !== exp_flag(v, c)) flag_err++;
            if (bus.fin !== 1'b0) fin_err++;
            @(posedge clk); #1;
        end
        check({tag, "_addr_seq_errs"}, addr_err, 32'd0);
        check({tag, "_flag_errs"}, flag_err, 32'd0);
        check({tag, "_fin_early_errs"}, fin_err, 32'd0);
        check({tag, "_done_fin_en_flag"}, {bus.fin, bus.en, bus.flag}, {29'd0, 3'b100});
        check({tag, "_result"}, bus.result, {22'd0, vecs[v].res});
        check({tag, "_done_addr"}, bus.addr, 32'd1023);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, {bus.fin, bus.en, bus.addr, bus.result},
              {20'd0, 1'b1, 1'b0, 10'd1023, vecs[v].res});
        bus.start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{10'h000, 1'b0, 10'd5,   10'h000,        1'b0, 10'd900,  10'h000,        1'b0, 10'd0};
        vecs[1] = '{10'h00B, 1'b1, 10'd5,   10'h00B,        1'b1, 10'd900,  10'h00B,        1'b1, 10'd1023};
        vecs[2] = '{10'h000, 1'b0, 10'd5,   10'b1011000000, 1'b1, 10'd900,  10'b0001011000, 1'b1, 10'd2};
        vecs[3] = '{10'h000, 1'b0, 10'd3,   10'b1100000010, CIRC, 10'd10,   10'b1100000001, 1'b0, {9'd0, CIRC}};
        vecs[4] = '{10'h3FF, 1'b0, 10'd0,   10'b1011111111, 1'b1, 10'd1023, 10'b1111110110, 1'b1, 10'd2};
        vecs[5] = '{10'h2AA, 1'b0, 10'd512, 10'b0000010110, 1'b1, 10'd513,  10'b1101101101, 1'b1, 10'd2};

        bus.start = 1'b0;
        rst = 1'b0;
        for (int v = 0; v < 6; v++) begin
            load(v);
            apply_reset($sformatf("v%0d", v));
            scan(v, $sformatf("v%0d", v));
        end

        // Abort a scan at address 400 with an asynchronous reset, then rescan
        load(1);
        apply_reset("abort");
        bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (400) @(posedge clk);
        #1;
        check("abort_addr_before", bus.addr, 32'd400);
        check("abort_count_before", bus.result, 32'd400);
        #2;
        rst = 1'b0;
        #1;
        check("abort_async_clear", {bus.en, bus.fin, bus.flag, bus.addr, bus.result}, 32'd0);
        bus.start = 1'b0;
        load(2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_after", {bus.en, bus.fin, bus.addr}, 32'd0);
        scan(2, "rescan");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
